// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM state encoding, port owner and the NOP returned on a bus error.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
   localparam int          STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Owner selection for mem_arbiter: data has priority until it has been granted STREAK_MAX
// times in a row while fetch waits, then fetch is served once.
module arb_select
   import mem_arbiter_pkg::*;
#(
   parameter int STREAK_MAX = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   if_req,
   input  logic   d_req,
   input  logic   fetch_gnt,
   input  logic   data_gnt,
   output owner_t sel_owner
);

   localparam logic [STREAK_W-1:0] SMAX = STREAK_W'(STREAK_MAX);

   logic [STREAK_W-1:0] streak_q;
   logic                fetch_due;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_q <= '0;
      end else if (!if_req || fetch_gnt) begin
         streak_q <= '0;
      end else if (data_gnt && (streak_q != SMAX)) begin
         streak_q <= streak_q + 1'b1;
      end
   end

   assign fetch_due = if_req && (streak_q == SMAX);
   assign sel_owner = (d_req && !fetch_due) ? OWN_DATA : OWN_FETCH;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto one memory port, one outstanding transaction.
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int STREAK_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              stall_fetch,
   output logic              bus_err
);

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d, sel_owner, cur_owner;
   logic        any_req, ack, resp_done, wd_fire;
   logic [31:0] resp_data;

   assign any_req = if_req | d_req;

   arb_select #(.STREAK_MAX(STREAK_MAX)) u_select (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .d_req     (d_req),
      .fetch_gnt (if_gnt),
      .data_gnt  (d_gnt),
      .sel_owner (sel_owner)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q <= '0;
      end else if ((state_q == ST_RESP) && !mem_rvalid) begin
         wd_q <= wd_q + 1'b1;
      end else begin
         wd_q <= '0;
      end
   end

   // wd_q counts completed RESP cycles, so TIMEOUT-1 marks the TIMEOUT-th one
   assign wd_fire = (state_q == ST_RESP) && !mem_rvalid && (wd_q == WD_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign wd_fire        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_FETCH;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_REQ;
               owner_d = sel_owner;
            end
         end
         ST_REQ: begin
            if (mem_ready) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (mem_rvalid || wd_fire) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The selection is presented from IDLE already; the handshake itself only counts in REQ.
   assign cur_owner = (state_q == ST_IDLE) ? sel_owner : owner_q;
   assign ack       = (state_q == ST_REQ) && mem_ready;
   assign resp_done = (state_q == ST_RESP) && (mem_rvalid || wd_fire);
   assign resp_data = wd_fire ? NOP_INSN : mem_rdata;

   assign if_gnt      = ack && (owner_q == OWN_FETCH);
   assign d_gnt       = ack && (owner_q == OWN_DATA);
   assign if_rvalid   = resp_done && (owner_q == OWN_FETCH);
   assign d_rvalid    = resp_done && (owner_q == OWN_DATA);
   assign stall_fetch = if_req && !if_gnt;
   assign bus_err     = wd_fire;

   always_comb begin
      mem_req   = rst_n && (((state_q == ST_IDLE) && any_req) || (state_q == ST_REQ));
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (mem_req) begin
         if (cur_owner == OWN_DATA) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
         end else begin
            mem_addr  = if_addr;
            mem_be    = 4'hF;
         end
      end
      if_rdata = if_rvalid ? resp_data : '0;
      d_rdata  = d_rvalid  ? resp_data : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs checked 2ns later.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we, mem_ready, mem_rvalid;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_be;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, stall_fetch, bus_err;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .STREAK_MAX(4), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall_fetch(stall_fetch), .bus_err(bus_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic quiet_inputs();
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
      d_wdata = '0; d_be = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   initial begin
      // reset with every input active: outputs silent, stall follows if_req
      quiet_inputs();
      rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1;
      if_addr = 32'h40; d_addr = 32'h80;
      #2;
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_gnt", 32'(if_gnt), 0);
      check("rst_d_gnt", 32'(d_gnt), 0);
      check("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 0);
      check("rst_bus_err", 32'(bus_err), 0);
      check("rst_stall_hi", 32'(stall_fetch), 1);
      if_req = 1'b0; #1;
      check("rst_stall_lo", 32'(stall_fetch), 0);

      @(negedge clk); rst_n = 1'b1; quiet_inputs(); #2;
      check("idle_mem_req", 32'(mem_req), 0);

      // fetch only
      @(negedge clk); if_req = 1'b1; if_addr = 32'h0100_0000; #2;
      check("f_req", 32'(mem_req), 1);
      check("f_addr", mem_addr, 32'h0100_0000);
      check("f_we_be", {27'b0, mem_we, mem_be}, 32'h0F);
      check("f_stall_wait", 32'(stall_fetch), 1);
      @(negedge clk); mem_ready = 1'b1; #2;
      check("f_gnt", 32'(if_gnt), 1);
      check("f_stall_gnt", 32'(stall_fetch), 0);
      @(negedge clk); if_req = 1'b0; mem_ready = 1'b0; #2;
      check("f_resp_wait", {30'b0, mem_req, if_rvalid}, 0);
      @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #2;
      check("f_rvalid", 32'(if_rvalid), 1);
      check("f_rdata", if_rdata, 32'hDEAD_BEEF);
      check("f_d_rvalid", 32'(d_rvalid), 0);
      @(negedge clk); quiet_inputs(); #2;
      check("f_rvalid_pulse", 32'(if_rvalid), 0);
      check("f_gnt_pulse", 32'(if_gnt), 0);

      // simultaneous fetch and load: data first
      @(negedge clk); if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200; d_be = 4'hF; #2;
      check("sim_first_addr", mem_addr, 32'h200);
      check("sim_stall0", 32'(stall_fetch), 1);
      @(negedge clk); mem_ready = 1'b1; #2;
      check("sim_d_gnt", {30'b0, d_gnt, if_gnt}, 32'h2);
      check("sim_stall1", 32'(stall_fetch), 1);
      @(negedge clk); d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001; #2;
      check("sim_d_rvalid", {30'b0, d_rvalid, if_rvalid}, 32'h2);
      check("sim_d_rdata", d_rdata, 32'hA5A5_0001);
      check("sim_stall2", 32'(stall_fetch), 1);
      @(negedge clk); mem_rvalid = 1'b0; mem_rdata = '0; #2;
      check("sim_second_addr", mem_addr, 32'h100);
      check("sim_stall3", 32'(stall_fetch), 1);
      @(negedge clk); mem_ready = 1'b1; #2;
      check("sim_f_gnt", {30'b0, d_gnt, if_gnt}, 32'h1);
      check("sim_stall_end", 32'(stall_fetch), 0);
      @(negedge clk); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11; #2;
      check("sim_f_rvalid", 32'(if_rvalid), 1);
      @(negedge clk); quiet_inputs();

      // both held high: 4 data grants, 1 fetch grant, repeating
      if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_addr = 32'h2000; d_be = 4'hF;
      for (int i = 0; i < 10; i++) begin
         bit exp_f;
         exp_f = ((i % 5) == 4);
         if (i != 0) @(negedge clk);
         mem_ready = 1'b0; mem_rvalid = 1'b0; #2;
         check("streak_sel", mem_addr, exp_f ? 32'h1000 : 32'h2000);
         @(negedge clk); mem_ready = 1'b1; #2;
         check("streak_gnt", {30'b0, d_gnt, if_gnt}, exp_f ? 32'h1 : 32'h2);
         @(negedge clk); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(i); #2;
         check("streak_rvalid", {30'b0, d_rvalid, if_rvalid}, exp_f ? 32'h1 : 32'h2);
      end
      @(negedge clk); quiet_inputs();

      // byte store
      @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234; d_be = 4'b0011; #2;
      check("st_we_be", {27'b0, mem_we, mem_be}, 32'h13);
      check("st_wdata", mem_wdata, 32'h1234);
      check("st_addr", mem_addr, 32'h300);
      @(negedge clk); mem_ready = 1'b1; #2;
      check("st_gnt", {30'b0, d_gnt, if_gnt}, 32'h2);
      check("st_we_hold", 32'(mem_we), 1);
      @(negedge clk); d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; #2;
      check("st_ack", {30'b0, d_rvalid, if_rvalid}, 32'h2);
      @(negedge clk); quiet_inputs();

      // reset during RESP, then a stray response
      @(negedge clk); if_req = 1'b1; if_addr = 32'h500; #2;
      @(negedge clk); mem_ready = 1'b1; #2;
      check("rr_gnt", 32'(if_gnt), 1);
      @(negedge clk); mem_ready = 1'b0; rst_n = 1'b0; #2;
      check("rr_mem_req", 32'(mem_req), 0);
      check("rr_stall", 32'(stall_fetch), 1);
      @(negedge clk); rst_n = 1'b1; quiet_inputs();
      @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hBAD; #2;
      check("rr_stray", {30'b0, d_rvalid, if_rvalid}, 0);
      @(negedge clk); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h504; #2;
      check("rr_idle_req", 32'(mem_req), 1);
      @(negedge clk); mem_ready = 1'b1; #2;
      check("rr_new_gnt", 32'(if_gnt), 1);
      @(negedge clk); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; #2;
      check("rr_new_rdata", if_rdata, 32'h77);
      @(negedge clk); quiet_inputs();

`ifdef MEM_ARB_TIMEOUT_EN
      // watchdog: response never comes
      @(negedge clk); if_req = 1'b1; if_addr = 32'h600; #2;
      @(negedge clk); mem_ready = 1'b1; #2;
      check("wd_gnt", 32'(if_gnt), 1);
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk); if_req = 1'b0; mem_ready = 1'b0; #2;
         if (c < 64) begin
            check("wd_quiet", {30'b0, bus_err, if_rvalid}, 0);
         end else begin
            check("wd_fire", {30'b0, bus_err, if_rvalid}, 32'h3);
            check("wd_nop", if_rdata, 32'h0000_0013);
         end
      end
      @(negedge clk); #2;
      check("wd_after", {30'b0, bus_err, mem_req}, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
